div_restoring_top: RTL and testbench
====================================

# div_restoring_top

Sequential restoring divider implementing RV32M DIV, DIVU, REM and REMU. It is the inverse-operation companion to the Booth radix-8 multiplier and sits beside it in the execute stage's MULT-DIV unit. The unit latches its operands on a start request and produces one quotient bit per clock over `length` iterations. It reports completion with a one-cycle finish pulse and holds the result until the next operation.

## Interface
- `length`, 32, operand/result width; iteration count equals `length`.

- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `OPER_A` in `length`: dividend (rs1).
- `OPER_B` in `length`: divisor (rs2).
- `ENABLE_DIV` in 1: start request; sampled only in IDLE.
- `FUCT3` in 2: funct3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `DIV_O` out `length`: quotient or remainder, registered.
- `DIV_FINISH` out 1: one-cycle completion pulse.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE, ENABLE_DIV=1:**
  - Latch OPER_A, OPER_B and FUCT3.
  - Signed flag = !FUCT3[0].
  - For signed ops, store magnitudes |A| and |B|, plus sign_q = A[msb]^B[msb] and sign_r = A[msb].
  - Clear the remainder register and the counter.
  - Next state is BUSY, except for the special cases below.
- **Special cases (decided in IDLE, go straight to DONE):**
  - B==0: quotient = all ones (0xFFFFFFFF); remainder = A (original, unsigned or signed alike).
  - Signed op with A==0x80000000 and B==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- **BUSY, one step per cycle:**
  - rem = {rem[length-2:0], dvd[msb]}; dvd <<= 1.
  - If rem >= divisor: rem -= divisor and shift 1 into quotient; else shift 0.
  - Use a `length+1`-bit subtractor so the comparison uses the borrow.
  - Counter increments each step; after step `length` (counter == length-1), go to DONE.
- **Result load (on the BUSY->DONE edge):**
  - Signed ops: quotient is negated if sign_q; remainder is negated if sign_r.
  - DIV_O = quotient when FUCT3[1]=0, remainder when FUCT3[1]=1.
- **DONE:**
  - DIV_FINISH=1 for exactly this cycle; next state is IDLE unconditionally.
  - ENABLE_DIV is ignored while in DONE.
- **Holding and restarts:**
  - DIV_O holds its value through IDLE until the next result load.
  - The core must drop ENABLE_DIV in the DIV_FINISH cycle; if it is still high in IDLE the next cycle, a new operation starts.
- **Ignored inputs:** ENABLE_DIV, OPER_A/B and FUCT3 changes during BUSY or DONE have no effect, because the operands are latched.

## Timing
- **Reset:** RST=1 at any edge forces IDLE, DIV_O=0, DIV_FINISH=0, counter=0 and data registers=0.
  - Reset mid-BUSY aborts the operation; no DIV_FINISH is produced.
  - RST has priority over ENABLE_DIV.
- **Normal latency:**
  - ENABLE_DIV sampled high at edge 0.
  - BUSY occupies cycles 1..`length`.
  - DIV_FINISH high in cycle `length`+1 (cycle 33 for length=32), with DIV_O valid in the same cycle.
- **Special-case latency:** ENABLE_DIV at edge 0 gives DIV_FINISH in cycle 1.
- **Throughput:** minimum issue spacing is `length`+2 cycles, since one IDLE cycle is needed between operations.
- **Outputs are glitch-free:** DIV_FINISH is decoded from the state register, and DIV_O comes straight from a register.

## Test plan
- **DIVU / REMU:** A=100, B=7.
  - DIVU gives DIV_O=14 with DIV_FINISH exactly 33 cycles after the start; REMU gives 2.
- **DIV / REM with negative operands:**
  - A=-100 (0xFFFFFF9C), B=7: DIV gives 0xFFFFFFF2 (-14); REM gives 0xFFFFFFFE (-2).
  - A=100, B=-7: REM gives 2.
- **Divide by zero:** A=0x12345678, B=0.
  - DIV and DIVU give 0xFFFFFFFF; REM and REMU give 0x12345678.
  - DIV_FINISH arrives 1 cycle after the start.
- **Signed overflow:** A=0x80000000, B=0xFFFFFFFF.
  - DIV gives 0x80000000; REM gives 0; latency 1.
  - The same operands with DIVU give 0 after 33 cycles.
- **Reset and handshake:**
  - Assert RST at BUSY cycle 10: DIV_FINISH never pulses and DIV_O=0.
  - Toggle OPER_A/B during BUSY: the result is unchanged.
  - Hold ENABLE_DIV high through DIV_FINISH: a second operation starts in the IDLE cycle after DONE.
- **Random regression:** 10k random signed and unsigned pairs, including 0, ±1, 0x7FFFFFFF and 0x80000000.
  - Check against the RISC-V reference model, and check that DIV_FINISH pulses exactly once per start.

Source files
------------

// File: rtl/div_restoring_top.sv
// Sequential restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per
// clock, one-cycle DIV_FINISH pulse, result held in DIV_O until the next load.
module div_restoring_top #(
  parameter int length = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [length-1:0] OPER_A,
  input  logic [length-1:0] OPER_B,
  input  logic              ENABLE_DIV,
  input  logic [1:0]        FUCT3,
  output logic [length-1:0] DIV_O,
  output logic              DIV_FINISH,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(length);
  localparam logic [length-1:0] MIN_NEG  = {1'b1, {(length-1){1'b0}}};
  localparam logic [length-1:0] ALL_ONES = {length{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [length-1:0] dvd_q, dvd_d;
  logic [length-1:0] dvs_q, dvs_d;
  logic [length-1:0] rem_q, rem_d;
  logic [length-1:0] quo_q, quo_d;
  logic [length-1:0] div_o_q, div_o_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        fct_q, fct_d;
  logic              sign_q_q, sign_q_d;
  logic              sign_r_q, sign_r_d;

  // Datapath for one restoring step, computed from the current registers.
  logic [length:0]   rem_sh;
  logic [length+1:0] diff;
  logic              borrow;
  logic [length-1:0] quo_step, rem_step, quo_fin, rem_fin;
  logic [length-1:0] abs_a, abs_b;
  logic              is_signed;

  always_comb begin
    rem_sh   = {rem_q, dvd_q[length-1]};
    // Partial remainder can reach 2*divisor-1, so the subtract needs two extra bits.
    diff     = {1'b0, rem_sh} - {2'b00, dvs_q};
    borrow   = diff[length+1];
    quo_step = {quo_q[length-2:0], ~borrow};
    rem_step = borrow ? rem_sh[length-1:0] : diff[length-1:0];
    quo_fin  = sign_q_q ? (~quo_step + 1'b1) : quo_step;
    rem_fin  = sign_r_q ? (~rem_step + 1'b1) : rem_step;

    is_signed = ~FUCT3[0];
    abs_a     = OPER_A[length-1] ? (~OPER_A + 1'b1) : OPER_A;
    abs_b     = OPER_B[length-1] ? (~OPER_B + 1'b1) : OPER_B;
  end

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_o_d  = div_o_q;
    cnt_d    = cnt_q;
    fct_d    = fct_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;

    case (state_q)
      IDLE: begin
        if (ENABLE_DIV) begin
          fct_d    = FUCT3;
          dvd_d    = is_signed ? abs_a : OPER_A;
          dvs_d    = is_signed ? abs_b : OPER_B;
          sign_q_d = is_signed & (OPER_A[length-1] ^ OPER_B[length-1]);
          sign_r_d = is_signed & OPER_A[length-1];
          rem_d    = '0;
          quo_d    = '0;
          cnt_d    = '0;
          if (OPER_B == '0) begin
            div_o_d = FUCT3[1] ? OPER_A : ALL_ONES;
            state_d = DONE;
          end else if (is_signed && OPER_A == MIN_NEG && OPER_B == ALL_ONES) begin
            div_o_d = FUCT3[1] ? '0 : MIN_NEG;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        dvd_d = {dvd_q[length-2:0], 1'b0};
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(length-1)) begin
          div_o_d = fct_q[1] ? rem_fin : quo_fin;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_o_q  <= '0;
      cnt_q    <= '0;
      fct_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_o_q  <= div_o_d;
      cnt_q    <= cnt_d;
      fct_q    <= fct_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
    end
  end

  assign DIV_O      = div_o_q;
  assign DIV_FINISH = (state_q == DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_div_restoring_top.sv
// Directed bench for div_restoring_top: hand-computed RV32M vectors, latency,
// finish-pulse, reset-abort, operand-hold and back-to-back restart checks.
module tb_div_restoring_top;

  localparam int W = 32;
  localparam logic [1:0] F_DIV = 2'b00, F_DIVU = 2'b01, F_REM = 2'b10, F_REMU = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;

  logic          clk;
  logic          rst;
  logic [W-1:0]  oper_a, oper_b;
  logic          enable_div;
  logic [1:0]    fuct3;
  logic [W-1:0]  div_o;
  logic          div_finish;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  div_restoring_top #(.length(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .OPER_A     (oper_a),
    .OPER_B     (oper_b),
    .ENABLE_DIV (enable_div),
    .FUCT3      (fuct3),
    .DIV_O      (div_o),
    .DIV_FINISH (div_finish),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent RISC-V reference: language-level signed/unsigned division.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] f);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f)
      F_DIV:   if (b == 0) return '1;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
               else return W'(sa / sb);
      F_DIVU:  if (b == 0) return '1; else return a / b;
      F_REM:   if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
               else return W'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Driver: start one op, optionally disturb inputs during BUSY, check result,
  // latency and single-cycle finish pulse.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] f, input logic [W-1:0] exp, input int exp_lat,
                        input bit disturb);
    int lat;
    logic [W-1:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    oper_a = a; oper_b = b; fuct3 = f; enable_div = 1'b1;
    @(posedge clk); #1;
    enable_div = 1'b0;
    lat = 1;
    while (!div_finish && lat < 40) begin
      if (disturb) begin
        oper_a = $urandom; oper_b = $urandom;
        fuct3 = 2'($urandom_range(0, 3)); enable_div = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    enable_div = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".finish"}, W'(div_finish), W'(1));
    check({tag, ".latency"}, W'(lat), W'(exp_lat));
    check({tag, ".value"}, div_o, e);
    @(posedge clk); #1;
    check({tag, ".pulse_drop"}, W'(div_finish), W'(0));
    check({tag, ".hold"}, div_o, e);
  endtask

  initial begin
    int lat, pulses;
    logic [W-1:0] ra, rb;
    logic [1:0] rf;
    logic [W-1:0] corners [5];
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h8000_0000;

    rst = 1'b1; oper_a = '0; oper_b = '0; enable_div = 1'b0; fuct3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.div_o", div_o, '0);
    check("reset.finish", W'(div_finish), W'(0));
    check("reset.state", W'(dbg_state), W'(S_IDLE));
    @(negedge clk); rst = 1'b0;

    // Basic unsigned and signed vectors
    run_op("divu_100_7", 32'd100, 32'd7, F_DIVU, 32'd14, 33, 1'b0);
    run_op("remu_100_7", 32'd100, 32'd7, F_REMU, 32'd2, 33, 1'b0);
    run_op("div_m100_7", 32'hFFFF_FF9C, 32'd7, F_DIV, 32'hFFFF_FFF2, 33, 1'b0);
    run_op("rem_m100_7", 32'hFFFF_FF9C, 32'd7, F_REM, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("rem_100_m7", 32'd100, 32'hFFFF_FFF9, F_REM, 32'd2, 33, 1'b0);
    run_op("div_100_m7", 32'd100, 32'hFFFF_FFF9, F_DIV, 32'hFFFF_FFF2, 33, 1'b0);
    run_op("divu_big", 32'hFFFF_FFFE, 32'h8000_0001, F_DIVU, 32'd1, 33, 1'b0);
    run_op("remu_big", 32'hFFFF_FFFE, 32'h8000_0001, F_REMU, 32'h7FFF_FFFD, 33, 1'b0);

    // Divide by zero
    run_op("div_by0", 32'h1234_5678, 32'd0, F_DIV, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("divu_by0", 32'h1234_5678, 32'd0, F_DIVU, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("rem_by0", 32'h1234_5678, 32'd0, F_REM, 32'h1234_5678, 1, 1'b0);
    run_op("remu_by0", 32'h1234_5678, 32'd0, F_REMU, 32'h1234_5678, 1, 1'b0);

    // Signed overflow and its unsigned counterpart
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, F_DIV, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, F_REM, 32'd0, 1, 1'b0);
    run_op("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, F_DIVU, 32'd0, 33, 1'b0);

    // Inputs toggled while BUSY must not affect the result
    run_op("divu_disturb", 32'd100, 32'd7, F_DIVU, 32'd14, 33, 1'b1);

    // Reset at BUSY cycle 10 aborts with no finish pulse
    @(negedge clk);
    oper_a = 32'd1000; oper_b = 32'd3; fuct3 = F_DIVU; enable_div = 1'b1;
    @(negedge clk);
    enable_div = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort.div_o", div_o, '0);
    check("rst_abort.state", W'(dbg_state), W'(S_IDLE));
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_finish) pulses++;
    end
    check("rst_abort.no_finish", W'(pulses), W'(0));
    check("rst_abort.div_o_after", div_o, '0);

    // ENABLE_DIV held through DONE: restart in the following IDLE cycle
    @(negedge clk);
    oper_a = 32'd100; oper_b = 32'd7; fuct3 = F_DIVU; enable_div = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!div_finish && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b.first_latency", W'(lat), W'(33));
    check("b2b.first_value", div_o, 32'd14);
    @(posedge clk); #1;
    check("b2b.idle_state", W'(dbg_state), W'(S_IDLE));
    oper_a = 32'hFFFF_FF9C; oper_b = 32'd7; fuct3 = F_DIV;
    @(posedge clk); #1;
    enable_div = 1'b0;
    check("b2b.restarted", W'(dbg_state != S_IDLE), W'(1));
    lat = 1;
    while (!div_finish && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b.second_latency", W'(lat), W'(33));
    check("b2b.second_value", div_o, 32'hFFFF_FFF2);
    @(posedge clk); #1;

    // Short random regression against the reference model, biased to corners
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 9));
      rf = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), ra, rb, rf, ref_div(ra, rb, rf),
             (rb == 0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 33,
             1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
